// File: rtl/mbist_pkg.sv
// ============================================================================
// mbist_pkg: shared FSM encoding and March C- element table for the BIST path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  localparam logic [2:0] ELEM_LAST = E5;

  // Descending address order applies only to E3 and E4.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == E3) || (e == E4);
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e == E1) || (e == E2) || (e == E3) || (e == E4);
  endfunction

  function automatic logic elem_rpol(input logic [2:0] e);
    return (e == E2) || (e == E4);
  endfunction

  function automatic logic elem_wpol(input logic [2:0] e);
    return (e == E1) || (e == E3);
  endfunction

  // Single-op elements: E0 writes, E5 reads.
  function automatic logic elem_first_wr(input logic [2:0] e);
    return (e == E0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/marchc_seq.sv
// ============================================================================
// marchc_seq: element/op/address counters that walk the March C- sequence.
// Revision: 1.0
// ============================================================================
`default_nettype none

import mbist_pkg::*;

module marchc_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  output logic              rd_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              rpol_o,
  output logic              wpol_o,
  output logic [2:0]        elem_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [2:0]        elem_q, elem_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_end;
  logic              two_ops;
  logic              down;

  assign two_ops  = elem_two_ops(elem_q);
  assign down     = elem_down(elem_q);
  assign addr_end = down ? (addr_q == '0) : (addr_q == ADDR_MAX);

  always_comb begin
    elem_d = elem_q;
    op_d   = op_q;
    addr_d = addr_q;
    if (load_i) begin
      elem_d = E0;
      op_d   = 1'b0;
      addr_d = '0;
    end else if (step_i) begin
      if (two_ops && !op_q) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (addr_end) begin
          // Reload the start address for the next element's direction.
          elem_d = elem_q + 3'd1;
          addr_d = elem_down(elem_q + 3'd1) ? ADDR_MAX : '0;
        end else begin
          addr_d = down ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q <= E0;
      op_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      elem_q <= elem_d;
      op_q   <= op_d;
      addr_q <= addr_d;
    end
  end

  assign rd_o   = two_ops ? !op_q : !elem_first_wr(elem_q);
  assign wr_o   = two_ops ?  op_q :  elem_first_wr(elem_q);
  assign addr_o = addr_q;
  assign rpol_o = elem_rpol(elem_q);
  assign wpol_o = elem_wpol(elem_q);
  assign elem_o = elem_q;
  assign last_o = (elem_q == ELEM_LAST) && addr_end;

endmodule

`default_nettype wire

// File: rtl/marchc_engine.sv
// ============================================================================
// marchc_engine: March C- BIST engine; FSM, read-compare pipeline, fail log.
// Optional first-failure log enabled by MARCHC_FAIL_LOG_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

import mbist_pkg::*;

module marchc_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              marchc_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              marchc_complete,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  state_e            state_q, state_d;
  logic              start;
  logic              seq_rd, seq_wr, seq_rpol, seq_wpol, seq_last;
  logic [ADDR_W-1:0] seq_addr;
  logic [2:0]        seq_elem;
  logic              pend_q;
  logic [DATA_W-1:0] exp_q;
  logic              fail_q;
  logic              mismatch;

  assign start = (state_q == ST_IDLE) && marchc_en;

  marchc_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start),
    .step_i (state_q == ST_RUN),
    .rd_o   (seq_rd),
    .wr_o   (seq_wr),
    .addr_o (seq_addr),
    .rpol_o (seq_rpol),
    .wpol_o (seq_wpol),
    .elem_o (seq_elem),
    .last_o (seq_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (marchc_en) state_d = ST_RUN;
      ST_RUN:   if (!marchc_en) state_d = ST_IDLE;
                else if (seq_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = marchc_en ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!marchc_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    marchc_complete = 1'b0;
    case (state_q)
      ST_RUN: begin
        mem_we   = seq_wr;
        mem_re   = seq_rd;
        mem_addr = seq_addr;
        if (seq_wr) mem_wdata = {DATA_W{seq_wpol}};
      end
      ST_DONE: marchc_complete = 1'b1;
      default: ;
    endcase
  end

  // A compare whose cycle sees marchc_en low belongs to an aborted run and is dropped.
  assign mismatch = pend_q && marchc_en && (mem_rdata != exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      exp_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      pend_q <= mem_re && marchc_en;
      if (mem_re) exp_q <= {DATA_W{seq_rpol}};
      if (start)         fail_q <= 1'b0;
      else if (mismatch) fail_q <= 1'b1;
    end
  end

  assign fail = fail_q;

`ifdef MARCHC_FAIL_LOG_EN
  logic [ADDR_W-1:0] paddr_q, fail_addr_q;
  logic [2:0]        pelem_q, fail_elem_q;
  logic [DATA_W-1:0] fail_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_q     <= '0;
      pelem_q     <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else begin
      if (mem_re) begin
        paddr_q <= mem_addr;
        pelem_q <= seq_elem;
      end
      if (start) begin
        fail_addr_q <= '0;
        fail_elem_q <= '0;
        fail_data_q <= '0;
      end else if (mismatch && !fail_q) begin
        fail_addr_q <= paddr_q;
        fail_elem_q <= pelem_q;
        fail_data_q <= mem_rdata;
      end
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;
`else
  logic unused_elem;
  assign unused_elem = ^seq_elem;

  assign fail_addr = '0;
  assign fail_elem = '0;
  assign fail_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_marchc_engine.sv
// ============================================================================
// tb_marchc_engine: directed bench for marchc_engine with a RAM model and an
// op scoreboard built from an independent March C- expansion.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_marchc_engine;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int NOPS   = 10 * DEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              marchc_en = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              marchc_complete;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [DATA_W-1:0] fail_data;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [7:0]  wdata;
  } op_t;

  op_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ram [DEPTH];
  bit          fault_en = 1'b0;

`ifdef MARCHC_FAIL_LOG_EN
  localparam logic [3:0] FLT_ADDR = 4'd5;
  localparam logic [2:0] FLT_ELEM = 3'd2;
  localparam logic [7:0] FLT_DATA = 8'hF7;
`else
  localparam logic [3:0] FLT_ADDR = 4'd0;
  localparam logic [2:0] FLT_ELEM = 3'd0;
  localparam logic [7:0] FLT_DATA = 8'h00;
`endif

  marchc_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .marchc_en       (marchc_en),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_re          (mem_re),
    .mem_rdata       (mem_rdata),
    .marchc_complete (marchc_complete),
    .fail            (fail),
    .fail_addr       (fail_addr),
    .fail_elem       (fail_elem),
    .fail_data       (fail_data)
  );

  always #5 clk = ~clk;

  // Synchronous RAM; optional stuck-at-0 on bit 3 of address 5.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (fault_en && mem_addr == 4'd5) ? (ram[mem_addr] & 8'hF7)
                                                            : ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] all_outs();
    return {mem_we, mem_re, mem_addr, mem_wdata, marchc_complete,
            fail, fail_addr, fail_elem, fail_data};
  endfunction

  function automatic op_t bus();
    return {mem_we, mem_re, mem_addr, mem_wdata};
  endfunction

  task automatic push_run();
    for (int e = 0; e < 6; e++) begin
      bit         down = (e == 3) || (e == 4);
      bit         wp   = (e == 1) || (e == 3);
      for (int i = 0; i < DEPTH; i++) begin
        logic [3:0] a = down ? 4'(DEPTH - 1 - i) : 4'(i);
        if (e == 0)      sb.push_back({1'b1, 1'b0, a, 8'h00});
        else if (e == 5) sb.push_back({1'b0, 1'b1, a, 8'h00});
        else begin
          sb.push_back({1'b0, 1'b1, a, 8'h00});
          sb.push_back({1'b1, 1'b0, a, wp ? 8'hFF : 8'h00});
        end
      end
    end
  endtask

  // Raise marchc_en (assumed low) and check the first n issued ops.
  task automatic start_and_check(input int n, output int nwe, output int nre);
    op_t o;
    nwe = 0;
    nre = 0;
    push_run();
    @(negedge clk) marchc_en = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      o = sb.pop_front();
      chk($sformatf("op%0d", k), 32'(bus()), 32'(o));
      nwe += int'(mem_we);
      nre += int'(mem_re);
    end
  endtask

  task automatic full_run(input bit fault, input bit ef, input logic [3:0] ea,
                          input logic [2:0] ee, input logic [7:0] ed);
    int nwe, nre;
    fault_en = fault;
    start_and_check(NOPS, nwe, nre);
    chk("complete_last_op", 32'(marchc_complete), 32'd0);
    @(negedge clk);
    chk("drain_bus_quiet", 32'(bus()), 32'd0);
    chk("drain_complete", 32'(marchc_complete), 32'd0);
    @(negedge clk);
    chk("complete_at_T161", 32'(marchc_complete), 32'd1);
    chk("we_pulses", 32'(nwe), 32'd80);
    chk("re_pulses", 32'(nre), 32'd80);
    chk("fail", 32'(fail), 32'(ef));
    chk("fail_addr", 32'(fail_addr), 32'(ea));
    chk("fail_elem", 32'(fail_elem), 32'(ee));
    chk("fail_data", 32'(fail_data), 32'(ed));
  endtask

  initial begin
    int nwe, nre;

    @(negedge clk);
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'(all_outs()), 32'd0);

    full_run(1'b0, 1'b0, 4'd0, 3'd0, 8'h00);

    // Held in DONE: complete stays up with the RAM quiet.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_complete", 32'(marchc_complete), 32'd1);
      chk("hold_bus_quiet", 32'(bus()), 32'd0);
    end
    @(negedge clk) marchc_en = 1'b0;

    full_run(1'b1, 1'b1, FLT_ADDR, FLT_ELEM, FLT_DATA);

    // Abort 50 ops into a run that follows a failing run.
    @(negedge clk) marchc_en = 1'b0;
    fault_en = 1'b1;
    start_and_check(50, nwe, nre);
    marchc_en = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_bus_quiet", 32'(bus()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_complete", 32'(marchc_complete), 32'd0);
    end
    chk("abort_fail_cleared", 32'(fail), 32'd0);

    full_run(1'b0, 1'b0, 4'd0, 3'd0, 8'h00);

    // Reset asserted 70 ops into a run that has already logged a failure.
    @(negedge clk) marchc_en = 1'b0;
    fault_en = 1'b1;
    start_and_check(70, nwe, nre);
    chk("pre_reset_fail", 32'(fail), 32'd1);
    rst_n = 1'b0;
    marchc_en = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_outputs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    chk("held_reset_outputs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    full_run(1'b0, 1'b0, 4'd0, 3'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
